// File: rtl/maze_pkg.sv
// Shared parameters, direction encoding and player state type for the maze path player.
package maze_pkg;

  localparam int COORD_W = 4;
  localparam int STEP_W  = 8;

  localparam logic [1:0] DIR_PX = 2'b00;
  localparam logic [1:0] DIR_PY = 2'b01;
  localparam logic [1:0] DIR_NX = 2'b10;
  localparam logic [1:0] DIR_NY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_FIRST,
    S_LOAD_FIRST,
    S_FETCH,
    S_LOAD,
    S_EMIT,
    S_DONE,
    S_ERROR
  } play_state_t;

endpackage

// File: rtl/maze_path_player_if.sv
// Path-queue read port and move stream between the player and its neighbours.
interface maze_path_player_if #(
  parameter int COORD_W = maze_pkg::COORD_W
);
  logic                   queue_empty;
  logic [2*COORD_W-1:0]   queue_dout;
  logic                   queue_pop;
  logic                   move_valid;
  logic                   move_ready;
  logic [1:0]             move_dir;
  logic [COORD_W-1:0]     move_x;
  logic [COORD_W-1:0]     move_y;

  modport master (
    input  queue_empty, queue_dout, move_ready,
    output queue_pop, move_valid, move_dir, move_x, move_y
  );

  modport slave (
    output queue_empty, queue_dout, move_ready,
    input  queue_pop, move_valid, move_dir, move_x, move_y
  );
endinterface

// File: rtl/maze_step_decoder.sv
// Combinational prev->cur step decode: direction and 4-neighbour adjacency test.
module maze_step_decoder #(
  parameter int COORD_W = maze_pkg::COORD_W
) (
  input  logic [2*COORD_W-1:0] prev,
  input  logic [2*COORD_W-1:0] cur,
  output logic [1:0]           dir,
  output logic                 adjacent
);
  import maze_pkg::*;

  // One spare bit so that max coordinate + 1 never wraps to 0.
  logic [COORD_W:0] px, py, cx, cy;

  assign px = {1'b0, prev[2*COORD_W-1:COORD_W]};
  assign py = {1'b0, prev[COORD_W-1:0]};
  assign cx = {1'b0, cur[2*COORD_W-1:COORD_W]};
  assign cy = {1'b0, cur[COORD_W-1:0]};

  always_comb begin
    dir      = DIR_PX;
    adjacent = 1'b0;
    if (py == cy) begin
      if (cx == px + 1'b1) begin
        dir      = DIR_PX;
        adjacent = 1'b1;
      end else if (px == cx + 1'b1) begin
        dir      = DIR_NX;
        adjacent = 1'b1;
      end
    end else if (px == cx) begin
      if (cy == py + 1'b1) begin
        dir      = DIR_PY;
        adjacent = 1'b1;
      end else if (py == cy + 1'b1) begin
        dir      = DIR_NY;
        adjacent = 1'b1;
      end
    end
  end

endmodule

// File: rtl/maze_path_player.sv
// Replays the solved path queue as a valid/ready stream of single-cell moves.
module maze_path_player #(
  parameter int COORD_W = maze_pkg::COORD_W,
  parameter int STEP_W  = maze_pkg::STEP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_play,
  maze_path_player_if.master  bus,
  output logic [STEP_W-1:0]   step_count,
  output logic                busy,
  output logic                play_done,
  output logic                path_error
);
  import maze_pkg::*;

  play_state_t          state, state_nxt;
  logic [2*COORD_W-1:0] prev, cur;
  logic [1:0]           dec_dir;
  logic                 dec_adj;
  logic                 start_ok;
  logic                 handshake;

  // Decodes against the live queue head so the move is ready when LOAD registers it.
  maze_step_decoder #(.COORD_W(COORD_W)) u_dec (
    .prev     (prev),
    .cur      (bus.queue_dout),
    .dir      (dec_dir),
    .adjacent (dec_adj)
  );

  assign start_ok  = start_play && (state inside {S_IDLE, S_DONE, S_ERROR});
  assign handshake = (state == S_EMIT) && bus.move_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.queue_pop  = 1'b0;
    bus.move_valid = 1'b0;
    busy           = 1'b1;
    play_done      = 1'b0;
    path_error     = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        busy       = 1'b0;
        play_done  = (state == S_DONE);
        path_error = (state == S_ERROR);
        if (start_play) state_nxt = bus.queue_empty ? S_DONE : S_FETCH_FIRST;
      end
      S_FETCH_FIRST: begin
        if (!bus.queue_empty) begin
          bus.queue_pop = 1'b1;
          state_nxt     = S_LOAD_FIRST;
        end
      end
      S_LOAD_FIRST: state_nxt = bus.queue_empty ? S_DONE : S_FETCH;
      S_FETCH: begin
        if (!bus.queue_empty) begin
          bus.queue_pop = 1'b1;
          state_nxt     = S_LOAD;
        end
      end
      S_LOAD: state_nxt = dec_adj ? S_EMIT : S_ERROR;
      S_EMIT: begin
        bus.move_valid = 1'b1;
        if (bus.move_ready) state_nxt = bus.queue_empty ? S_DONE : S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev         <= '0;
      cur          <= '0;
      bus.move_dir <= '0;
      bus.move_x   <= '0;
      bus.move_y   <= '0;
      step_count   <= '0;
    end else begin
      if (start_ok) step_count <= '0;
      if (state == S_LOAD_FIRST) prev <= bus.queue_dout;
      if (state == S_LOAD) begin
        cur <= bus.queue_dout;
        if (dec_adj) begin
          bus.move_dir              <= dec_dir;
          {bus.move_x, bus.move_y}  <= bus.queue_dout;
        end
      end
      if (handshake) begin
        prev <= cur;
        if (step_count != '1) step_count <= step_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_maze_path_player.sv
// Directed bench for maze_path_player with a behavioural path queue and move recorder.
module tb_maze_path_player;

  logic       clk;
  logic       rst;
  logic       start_play;
  logic [7:0] step_count;
  logic       busy;
  logic       play_done;
  logic       path_error;

  int checks;
  int errors;

  maze_path_player_if #(.COORD_W(4)) bus ();

  maze_path_player #(.COORD_W(4), .STEP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_play (start_play),
    .bus        (bus),
    .step_count (step_count),
    .busy       (busy),
    .play_done  (play_done),
    .path_error (path_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue model, pop/handshake recorders
  logic [7:0] q_mem[$];
  logic [9:0] mv_q[$];
  int         hs_cyc[$];
  int         pops;
  int         pop_empty;
  int         valid_cnt;
  int         cyc;

  initial begin
    pops = 0; pop_empty = 0; valid_cnt = 0; cyc = 0;
    bus.queue_dout = '0;
  end

  assign bus.queue_empty = (q_mem.size() == 0);

  always @(posedge clk) begin
    if (bus.queue_pop) begin
      pops = pops + 1;
      if (q_mem.size() == 0) pop_empty = pop_empty + 1;
      else bus.queue_dout <= q_mem.pop_front();
    end
    if (bus.move_valid) valid_cnt = valid_cnt + 1;
    if (bus.move_valid && bus.move_ready) begin
      mv_q.push_back({bus.move_dir, bus.move_x, bus.move_y});
      hs_cyc.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  function automatic logic [9:0] mv(input logic [1:0] d, input int x, input int y);
    return {d, x[3:0], y[3:0]};
  endfunction

  task automatic push_cell(input int x, input int y);
    q_mem.push_back({x[3:0], y[3:0]});
  endtask

  task automatic pulse_start;
    @(negedge clk) start_play = 1'b1;
    @(negedge clk) start_play = 1'b0;
  endtask

  task automatic wait_end(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (play_done || path_error) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    checks++; if (bus.move_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.move_valid); end
    checks++; if (bus.queue_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", bus.queue_pop); end
    checks++; if (step_count !== 8'd0) begin errors++; $display("FAIL reset_steps: got %0d expected 0", step_count); end
    checks++; if ({busy, play_done, path_error} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, play_done, path_error}); end
    checks++; if ({bus.move_dir, bus.move_x, bus.move_y} !== 10'd0) begin errors++; $display("FAIL reset_move: got %h expected 0", {bus.move_dir, bus.move_x, bus.move_y}); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic;
    int p0, m0, lat; bit ok;
    p0 = pops; m0 = mv_q.size(); bus.move_ready = 1'b1;
    push_cell(0,0); push_cell(1,0); push_cell(1,1); push_cell(2,1);
    pulse_start();
    lat = 0;
    while (!bus.move_valid && lat < 20) begin lat++; @(negedge clk); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    wait_end(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got 0 expected 1"); end
    checks++; if (mv_q.size() - m0 !== 3) begin errors++; $display("FAIL basic_nmoves: got %0d expected 3", mv_q.size() - m0); end
    if (mv_q.size() - m0 >= 3) begin
      checks++; if (mv_q[m0]   !== mv(2'b00,1,0)) begin errors++; $display("FAIL basic_move1: got %h expected %h", mv_q[m0],   mv(2'b00,1,0)); end
      checks++; if (mv_q[m0+1] !== mv(2'b01,1,1)) begin errors++; $display("FAIL basic_move2: got %h expected %h", mv_q[m0+1], mv(2'b01,1,1)); end
      checks++; if (mv_q[m0+2] !== mv(2'b00,2,1)) begin errors++; $display("FAIL basic_move3: got %h expected %h", mv_q[m0+2], mv(2'b00,2,1)); end
      checks++; if (hs_cyc[m0+1] - hs_cyc[m0] !== 3) begin errors++; $display("FAIL basic_rate: got %0d expected 3", hs_cyc[m0+1] - hs_cyc[m0]); end
    end
    checks++; if (step_count !== 8'd3) begin errors++; $display("FAIL basic_steps: got %0d expected 3", step_count); end
    checks++; if (play_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", play_done); end
    checks++; if (pops - p0 !== 4) begin errors++; $display("FAIL basic_pops: got %0d expected 4", pops - p0); end
  endtask

  task automatic test_stall;
    int p0, m0, n; bit ok;
    p0 = pops; m0 = mv_q.size(); bus.move_ready = 1'b1;
    push_cell(0,0); push_cell(1,0); push_cell(1,1); push_cell(2,1);
    pulse_start();
    n = 0;
    while (mv_q.size() == m0 && n < 30) begin n++; @(negedge clk); end
    bus.move_ready = 1'b0;
    n = 0;
    while (!bus.move_valid && n < 30) begin n++; @(negedge clk); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.move_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b expected 1", i, bus.move_valid); end
      checks++; if ({bus.move_dir, bus.move_x, bus.move_y} !== mv(2'b01,1,1)) begin errors++; $display("FAIL stall_data%0d: got %h expected %h", i, {bus.move_dir, bus.move_x, bus.move_y}, mv(2'b01,1,1)); end
      checks++; if (step_count !== 8'd1) begin errors++; $display("FAIL stall_steps%0d: got %0d expected 1", i, step_count); end
      checks++; if (pops - p0 !== 3) begin errors++; $display("FAIL stall_pops%0d: got %0d expected 3", i, pops - p0); end
      @(negedge clk);
    end
    bus.move_ready = 1'b1;
    wait_end(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got 0 expected 1"); end
    checks++; if (mv_q.size() - m0 !== 3) begin errors++; $display("FAIL stall_nmoves: got %0d expected 3", mv_q.size() - m0); end
    if (mv_q.size() - m0 >= 3) begin
      checks++; if (mv_q[m0+2] !== mv(2'b00,2,1)) begin errors++; $display("FAIL stall_move3: got %h expected %h", mv_q[m0+2], mv(2'b00,2,1)); end
    end
    checks++; if (step_count !== 8'd3) begin errors++; $display("FAIL stall_steps_end: got %0d expected 3", step_count); end
    checks++; if (pops - p0 !== 4) begin errors++; $display("FAIL stall_pops_end: got %0d expected 4", pops - p0); end
  endtask

  task automatic test_empty;
    int p0, v0;
    p0 = pops; v0 = valid_cnt;
    pulse_start();
    checks++; if (play_done !== 1'b1) begin errors++; $display("FAIL empty_done: got %b expected 1", play_done); end
    checks++; if (step_count !== 8'd0) begin errors++; $display("FAIL empty_steps: got %0d expected 0", step_count); end
    repeat (3) @(negedge clk);
    checks++; if (pops - p0 !== 0) begin errors++; $display("FAIL empty_pops: got %0d expected 0", pops - p0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL empty_valid: got %0d expected 0", valid_cnt - v0); end
  endtask

  task automatic test_single_and_dirs;
    int p0, m0; bit ok;
    p0 = pops; m0 = mv_q.size();
    push_cell(3,3);
    pulse_start();
    wait_end(50, ok);
    checks++; if (!(ok && play_done)) begin errors++; $display("FAIL single_done: got %b expected 1", play_done); end
    checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL single_pops: got %0d expected 1", pops - p0); end
    checks++; if (step_count !== 8'd0 || mv_q.size() != m0) begin errors++; $display("FAIL single_steps: got %0d expected 0", step_count); end
    push_cell(2,2); push_cell(2,1); push_cell(1,1);
    pulse_start();
    wait_end(50, ok);
    checks++; if (mv_q.size() - m0 !== 2) begin errors++; $display("FAIL dirs_nmoves: got %0d expected 2", mv_q.size() - m0); end
    if (mv_q.size() - m0 >= 2) begin
      checks++; if (mv_q[m0]   !== mv(2'b11,2,1)) begin errors++; $display("FAIL dirs_ny: got %h expected %h", mv_q[m0],   mv(2'b11,2,1)); end
      checks++; if (mv_q[m0+1] !== mv(2'b10,1,1)) begin errors++; $display("FAIL dirs_nx: got %h expected %h", mv_q[m0+1], mv(2'b10,1,1)); end
    end
    checks++; if (step_count !== 8'd2) begin errors++; $display("FAIL dirs_steps: got %0d expected 2", step_count); end
  endtask

  task automatic test_error;
    int p0, v0, m0; bit ok;
    p0 = pops; v0 = valid_cnt;
    push_cell(0,0); push_cell(2,0);
    pulse_start();
    wait_end(50, ok);
    checks++; if ({ok, path_error, play_done} !== 3'b110) begin errors++; $display("FAIL err_gap: got %b expected 110", {ok, path_error, play_done}); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL err_valid: got %0d expected 0", valid_cnt - v0); end
    checks++; if (pops - p0 !== 2) begin errors++; $display("FAIL err_pops: got %0d expected 2", pops - p0); end
    push_cell(15,3); push_cell(0,3);
    pulse_start();
    wait_end(50, ok);
    checks++; if ({ok, path_error} !== 2'b11) begin errors++; $display("FAIL err_wrap: got %b expected 11", {ok, path_error}); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL err_wrap_valid: got %0d expected 0", valid_cnt - v0); end
    m0 = mv_q.size();
    push_cell(5,5); push_cell(5,6);
    pulse_start();
    checks++; if (path_error !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", path_error); end
    wait_end(50, ok);
    checks++; if (mv_q.size() - m0 !== 1 || mv_q[m0] !== mv(2'b01,5,6)) begin errors++; $display("FAIL err_restart_move: got %h expected %h", mv_q[mv_q.size()-1], mv(2'b01,5,6)); end
    checks++; if ({play_done, path_error} !== 2'b10) begin errors++; $display("FAIL err_restart_done: got %b expected 10", {play_done, path_error}); end
  endtask

  task automatic test_saturate;
    int m0; bit ok;
    m0 = mv_q.size(); bus.move_ready = 1'b1;
    for (int i = 0; i < 301; i++) push_cell(i % 2, 0);
    pulse_start();
    wait_end(2000, ok);
    checks++; if (!(ok && play_done)) begin errors++; $display("FAIL sat_done: got %b expected 1", play_done); end
    checks++; if (mv_q.size() - m0 !== 300) begin errors++; $display("FAIL sat_nmoves: got %0d expected 300", mv_q.size() - m0); end
    checks++; if (step_count !== 8'd255) begin errors++; $display("FAIL sat_steps: got %0d expected 255", step_count); end
  endtask

  task automatic test_reset_mid;
    int p0, m0, n; bit ok;
    p0 = pops; bus.move_ready = 1'b0;
    push_cell(0,0); push_cell(1,0); push_cell(1,1); push_cell(2,1);
    pulse_start();
    n = 0;
    while (!bus.move_valid && n < 30) begin n++; @(negedge clk); end
    checks++; if (bus.move_valid !== 1'b1 || pops - p0 !== 2) begin errors++; $display("FAIL rstmid_emit: got valid=%b pops=%0d expected valid=1 pops=2", bus.move_valid, pops - p0); end
    rst = 1'b1;
    #1;
    checks++; if (bus.move_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", bus.move_valid); end
    checks++; if ({busy, play_done, path_error, bus.queue_pop} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b expected 0000", {busy, play_done, path_error, bus.queue_pop}); end
    checks++; if (step_count !== 8'd0 || {bus.move_dir, bus.move_x, bus.move_y} !== 10'd0) begin errors++; $display("FAIL rstmid_regs: got steps=%0d move=%h expected 0", step_count, {bus.move_dir, bus.move_x, bus.move_y}); end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    checks++; if (pops - p0 !== 2) begin errors++; $display("FAIL rstmid_nopop: got %0d expected 2", pops - p0); end
    bus.move_ready = 1'b1;
    p0 = pops; m0 = mv_q.size();
    pulse_start();
    wait_end(50, ok);
    checks++; if (mv_q.size() - m0 !== 1 || mv_q[m0] !== mv(2'b00,2,1)) begin errors++; $display("FAIL rstmid_replay: got n=%0d expected 1 move %h", mv_q.size() - m0, mv(2'b00,2,1)); end
    checks++; if (step_count !== 8'd1 || play_done !== 1'b1) begin errors++; $display("FAIL rstmid_end: got steps=%0d done=%b expected 1/1", step_count, play_done); end
    checks++; if (pops - p0 !== 2) begin errors++; $display("FAIL rstmid_pops: got %0d expected 2", pops - p0); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start_play = 1'b0; bus.move_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_single_and_dirs();
    test_error();
    test_saturate();
    test_reset_mid();
    checks++; if (pop_empty !== 0) begin errors++; $display("FAIL pop_on_empty: got %0d expected 0", pop_empty); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_path_player.md
Name: maze_path_player

Overview:
- Downstream stage of the maze solver controller; consumes the solved-path coordinate queue after the solver finishes.
- On a run request, pops cells in queue order and converts each consecutive pair into one move: direction plus destination cell.
- Emits moves over a valid/ready stream to the actuator/display side.
- Counts steps and flags malformed (non-adjacent) paths.

Parameters:
- COORD_W, 4, bits per coordinate (maze up to 16x16); queue entry is {x,y}, 2*COORD_W bits, x in upper half.
- STEP_W, 8, width of step counter; saturates at 2^STEP_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start_play  in  1  run request from top level; sampled in IDLE, DONE, ERROR; ignored otherwise.
- queue_empty  in  1  path queue has no entries.
- queue_dout  in  2*COORD_W  queue head data; valid the cycle after queue_pop.
- queue_pop  out  1  one-cycle pop strobe; never asserted when queue_empty=1.
- move_valid  out  1  move_dir/move_x/move_y hold a valid move.
- move_ready  in  1  consumer accepts the move.
- move_dir  out  2  direction: 00=+x, 01=+y, 10=-x, 11=-y.
- move_x  out  COORD_W  destination x.
- move_y  out  COORD_W  destination y.
- step_count  out  STEP_W  moves accepted since last start.
- busy  out  1  high in any state other than IDLE/DONE/ERROR.
- play_done  out  1  level, high in DONE.
- path_error  out  1  level, high in ERROR.

Behaviour:
- Reset: state IDLE; all outputs 0; prev/cur registers 0.
- States: IDLE, FETCH_FIRST, LOAD_FIRST, FETCH, LOAD, EMIT, DONE, ERROR.
- IDLE/DONE/ERROR with start_play=1:
  - clear step_count;
  - go to DONE if queue_empty=1, else FETCH_FIRST.
- FETCH_FIRST: queue_pop=1 -> LOAD_FIRST.
- LOAD_FIRST: prev <= queue_dout; queue_empty=1 -> DONE (single-cell path, 0 steps), else -> FETCH.
- FETCH: queue_pop=1 -> LOAD.
- LOAD: cur <= queue_dout; decode prev->cur.
  - Adjacent (|dx|+|dy|=1): register dir, move_x/y=cur -> EMIT.
  - Otherwise -> ERROR; no move emitted; queue not drained further.
- EMIT: move_valid=1. On move_valid & move_ready:
  - prev <= cur;
  - step_count+1 (saturating);
  - queue_empty=1 -> DONE, else -> FETCH.
- Stream rules:
  - move_dir/x/y stable while move_valid=1 & move_ready=0.
  - move_valid drops the cycle after a handshake.
  - move_ready is ignored outside EMIT.
- Throughput: one move per 3 cycles with move_ready tied high.
- Latency: start_play to first move_valid is 4 cycles (FETCH_FIRST, LOAD_FIRST, FETCH, LOAD).
- Adjacency arithmetic: unsigned COORD_W compare, no wrap; (15,y)->(0,y) is non-adjacent, so ERROR.
- queue_empty is sampled in LOAD_FIRST and EMIT only; a refill while busy is played normally.
- ERROR: path_error held high until rst or restart. DONE: play_done held high until rst or restart.
- rst mid-operation: immediate return to IDLE; move_valid drops asynchronously; no pop issued after rst.

Decomposition:
- Package maze_pkg:
  - COORD_W default;
  - direction encoding constants DIR_PX/DIR_PY/DIR_NX/DIR_NY;
  - player state encoding.
- One sub-module, maze_step_decoder: combinational; inputs prev and cur {x,y}; outputs dir[1:0] and adjacent.

Test Plan:
- Queue (0,0),(1,0),(1,1),(2,1), move_ready=1, pulse start_play:
  - moves (00,1,0), (01,1,1), (00,2,1);
  - step_count=3, play_done=1, exactly 4 pops.
- Same path with move_ready low for 5 cycles during move 2: move_valid and (01,1,1) held stable; no extra pop; step_count only 1 during the stall.
- Empty queue plus start_play: DONE next cycle, step_count=0, no pop, no move_valid.
- Single entry (3,3): one pop, DONE, step_count=0. Queue (2,2),(2,1),(1,1): dirs 11,10.
- Queue (0,0),(2,0): path_error=1, no move_valid; restart with valid queue (5,5),(5,6): clears error, emits 01, play_done=1.
- rst asserted mid-EMIT: outputs 0 immediately, state IDLE, step_count=0; next start_play replays the remaining queue contents correctly.
